// File: rtl/pd_pwr_pkg.sv
// pd_pwr_pkg: state encodings shared by the power-domain responder and its sleep handshake.
`default_nettype none

package pd_pwr_pkg;

  typedef enum logic [1:0] {
    OFF       = 2'b00,
    RAMP_UP   = 2'b01,
    ON        = 2'b11,
    RAMP_DOWN = 2'b10
  } pwr_state_t;

  typedef enum logic [1:0] {
    S_RUN   = 2'b00,
    S_DRAIN = 2'b01,
    S_ACK   = 2'b10
  } sleep_state_t;

endpackage

`default_nettype wire

// File: rtl/pd_sleep_hs.sv
// pd_sleep_hs: sleep request handshake; acks once the domain has been idle DRAIN_CYC cycles in a row.
`default_nettype none

module pd_sleep_hs
  import pd_pwr_pkg::*;
#(
  parameter int DRAIN_CYC = 3,
  parameter int CNT_W     = 8
) (
  input  logic         i_aon_clk,
  input  logic         i_soc_pwr_on_rst,
  input  logic         i_hw_sleep_req,
  input  logic         i_pd_idle,
  output logic         o_hw_sleep_ack,
  output sleep_state_t o_sleep_state
);

  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYC - 1);

  sleep_state_t     state, state_nxt;
  logic [CNT_W-1:0] idle_cnt, idle_cnt_nxt;

  always_ff @(posedge i_aon_clk or posedge i_soc_pwr_on_rst) begin
    if (i_soc_pwr_on_rst) begin
      state    <= S_RUN;
      idle_cnt <= '0;
    end else begin
      state    <= state_nxt;
      idle_cnt <= idle_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    idle_cnt_nxt = idle_cnt;
    case (state)
      S_RUN: begin
        if (i_hw_sleep_req) begin
          state_nxt    = S_DRAIN;
          idle_cnt_nxt = '0;
        end
      end
      S_DRAIN: begin
        // Any busy cycle restarts the drain window.
        if (!i_hw_sleep_req) begin
          state_nxt    = S_RUN;
          idle_cnt_nxt = '0;
        end else if (!i_pd_idle) begin
          idle_cnt_nxt = '0;
        end else if (idle_cnt == DRAIN_LAST) begin
          state_nxt = S_ACK;
        end else begin
          idle_cnt_nxt = idle_cnt + 1'b1;
        end
      end
      S_ACK: begin
        if (!i_hw_sleep_req) begin
          state_nxt    = S_RUN;
          idle_cnt_nxt = '0;
        end
      end
      default: begin
        state_nxt    = S_RUN;
        idle_cnt_nxt = '0;
      end
    endcase
  end

  assign o_hw_sleep_ack = (state == S_ACK);
  assign o_sleep_state  = state;

endmodule

`default_nettype wire

// File: rtl/pd_pwr_responder.sv
// pd_pwr_responder: power-switch ramp model, sleep handshake and retention strobes for one PD.
// Optional protocol checker enabled by defining PD_PROTO_CHK_EN.
`default_nettype none

module pd_pwr_responder
  import pd_pwr_pkg::*;
#(
  parameter int ON_DLY    = 8,
  parameter int OFF_DLY   = 4,
  parameter int DRAIN_CYC = 3,
  parameter int CNT_W     = 8
) (
  input  logic       i_aon_clk,
  input  logic       i_soc_pwr_on_rst,
  input  logic       i_pwr_on_req,
  input  logic       i_hw_sleep_req,
  input  logic       i_iso,
  input  logic       i_ret,
  input  logic       i_pd_idle,
  output logic       o_sw_en,
  output logic       o_pwr_on_ack,
  output logic       o_hw_sleep_ack,
  output logic       o_save_pulse,
  output logic       o_restore_pulse,
  output logic       o_proto_err,
  output logic [1:0] o_pwr_state
);

  localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(ON_DLY - 1);
  localparam logic [CNT_W-1:0] OFF_LAST = CNT_W'(OFF_DLY - 1);

  pwr_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             ack, ack_nxt;
  logic             sw_en;
  logic             ret_q, ret_rise, ret_fall;
  logic             save_pulse, restore_pulse, restore_pend;
  sleep_state_t     sleep_state;

  always_ff @(posedge i_aon_clk or posedge i_soc_pwr_on_rst) begin
    if (i_soc_pwr_on_rst) begin
      state <= OFF;
      cnt   <= '0;
      ack   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      ack   <= ack_nxt;
    end
  end

  // Ack changes only when a ramp completes, so aborted ramps leave it untouched.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ack_nxt   = ack;
    case (state)
      OFF: begin
        if (i_pwr_on_req) begin
          state_nxt = RAMP_UP;
          cnt_nxt   = '0;
        end
      end
      RAMP_UP: begin
        if (!i_pwr_on_req) begin
          state_nxt = RAMP_DOWN;
          cnt_nxt   = '0;
        end else if (cnt == ON_LAST) begin
          state_nxt = ON;
          cnt_nxt   = '0;
          ack_nxt   = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      ON: begin
        if (!i_pwr_on_req) begin
          state_nxt = RAMP_DOWN;
          cnt_nxt   = '0;
        end
      end
      RAMP_DOWN: begin
        if (i_pwr_on_req) begin
          state_nxt = RAMP_UP;
          cnt_nxt   = '0;
        end else if (cnt == OFF_LAST) begin
          state_nxt = OFF;
          cnt_nxt   = '0;
          ack_nxt   = 1'b0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
    endcase
  end

  assign sw_en = (state == RAMP_UP) || (state == ON);

  pd_sleep_hs #(
    .DRAIN_CYC (DRAIN_CYC),
    .CNT_W     (CNT_W)
  ) u_sleep_hs (
    .i_aon_clk        (i_aon_clk),
    .i_soc_pwr_on_rst (i_soc_pwr_on_rst),
    .i_hw_sleep_req   (i_hw_sleep_req),
    .i_pd_idle        (i_pd_idle),
    .o_hw_sleep_ack   (o_hw_sleep_ack),
    .o_sleep_state    (sleep_state)
  );

  assign ret_rise = i_ret & ~ret_q;
  assign ret_fall = ~i_ret & ret_q;

  // A restore requested while unpowered is deferred until power-good returns.
  always_ff @(posedge i_aon_clk or posedge i_soc_pwr_on_rst) begin
    if (i_soc_pwr_on_rst) begin
      ret_q         <= 1'b0;
      save_pulse    <= 1'b0;
      restore_pulse <= 1'b0;
      restore_pend  <= 1'b0;
    end else begin
      ret_q         <= i_ret;
      save_pulse    <= ret_rise;
      restore_pulse <= 1'b0;
      if (ret_rise) begin
        restore_pend <= 1'b0;
      end else if (ret_fall) begin
        if (ack) restore_pulse <= 1'b1;
        else     restore_pend  <= 1'b1;
      end else if (restore_pend && ack) begin
        restore_pulse <= 1'b1;
        restore_pend  <= 1'b0;
      end
    end
  end

`ifdef PD_PROTO_CHK_EN
  logic proto_err;
  logic drop_no_iso, save_undrained;

  assign drop_no_iso    = sw_en & ~i_pwr_on_req & ~i_iso;
  assign save_undrained = ret_rise & (sleep_state != S_ACK);

  always_ff @(posedge i_aon_clk or posedge i_soc_pwr_on_rst) begin
    if (i_soc_pwr_on_rst) proto_err <= 1'b0;
    else                  proto_err <= proto_err | drop_no_iso | save_undrained;
  end

  assign o_proto_err = proto_err;
`else
  logic unused_chk;
  assign unused_chk  = ^{i_iso, sleep_state};
  assign o_proto_err = 1'b0;
`endif

  assign o_sw_en         = sw_en;
  assign o_pwr_on_ack    = ack;
  assign o_save_pulse    = save_pulse;
  assign o_restore_pulse = restore_pulse;
  assign o_pwr_state     = state;

endmodule

`default_nettype wire

// File: tb/tb_pd_pwr_responder.sv
// tb_pd_pwr_responder: directed scenarios plus randomized run against a run-length reference model.
`default_nettype none

module tb_pd_pwr_responder;

  localparam int ON_DLY    = 8;
  localparam int OFF_DLY   = 4;
  localparam int DRAIN_CYC = 3;
  localparam int CNT_W     = 8;
`ifdef PD_PROTO_CHK_EN
  localparam logic CHK_EN = 1'b1;
`else
  localparam logic CHK_EN = 1'b0;
`endif

  logic clk  = 1'b0;
  logic rst  = 1'b1;
  logic req  = 1'b0;
  logic sreq = 1'b0;
  logic iso  = 1'b0;
  logic ret  = 1'b0;
  logic idle = 1'b0;

  logic       sw_en, ack, sack, save, restore, err;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pd_pwr_responder #(
    .ON_DLY    (ON_DLY),
    .OFF_DLY   (OFF_DLY),
    .DRAIN_CYC (DRAIN_CYC),
    .CNT_W     (CNT_W)
  ) dut (
    .i_aon_clk        (clk),
    .i_soc_pwr_on_rst (rst),
    .i_pwr_on_req     (req),
    .i_hw_sleep_req   (sreq),
    .i_iso            (iso),
    .i_ret            (ret),
    .i_pd_idle        (idle),
    .o_sw_en          (sw_en),
    .o_pwr_on_ack     (ack),
    .o_hw_sleep_ack   (sack),
    .o_save_pulse     (save),
    .o_restore_pulse  (restore),
    .o_proto_err      (err),
    .o_pwr_state      (state)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 1'b0; sreq = 1'b0; iso = 1'b0; ret = 1'b0; idle = 1'b0;
    tick(); tick();
    checks++;
    if ({sw_en, ack, sack, save, restore, err, state} !== 8'b0) begin
      errors++; $display("FAIL reset_outputs got=%b exp=00000000", {sw_en, ack, sack, save, restore, err, state});
    end
    rst = 1'b0;
    tick();
    checks++;
    if (state !== 2'b00) begin errors++; $display("FAIL reset_idle_state got=%b exp=00", state); end
  endtask

  task automatic test_power_up_down();
    iso = 1'b1; req = 1'b1;
    tick();
    checks++;
    if ({sw_en, ack, state} !== 4'b1001) begin errors++; $display("FAIL pu_start got=%b exp=1001", {sw_en, ack, state}); end
    repeat (ON_DLY - 1) tick();
    checks++;
    if (ack !== 1'b0) begin errors++; $display("FAIL pu_ack_early got=%b exp=0", ack); end
    tick();
    checks++;
    if ({sw_en, ack, state} !== 4'b1111) begin errors++; $display("FAIL pu_on got=%b exp=1111", {sw_en, ack, state}); end
    repeat (10) tick();
    req = 1'b0;
    tick();
    checks++;
    if ({sw_en, ack, state} !== 4'b0110) begin errors++; $display("FAIL pd_start got=%b exp=0110", {sw_en, ack, state}); end
    repeat (OFF_DLY - 1) tick();
    checks++;
    if (ack !== 1'b1) begin errors++; $display("FAIL pd_ack_early_drop got=%b exp=1", ack); end
    tick();
    checks++;
    if ({sw_en, ack, state} !== 4'b0000) begin errors++; $display("FAIL pd_off got=%b exp=0000", {sw_en, ack, state}); end
  endtask

  task automatic test_abort_up();
    iso = 1'b1; req = 1'b1;
    tick(); tick(); tick();
    req = 1'b0;
    tick();
    checks++;
    if ({sw_en, ack, state} !== 4'b0010) begin errors++; $display("FAIL abort_rampdown got=%b exp=0010", {sw_en, ack, state}); end
    for (int i = 0; i < OFF_DLY - 1; i++) begin
      tick();
      checks++;
      if ({ack, state} !== 3'b010) begin errors++; $display("FAIL abort_hold i=%0d got=%b exp=010", i, {ack, state}); end
    end
    tick();
    checks++;
    if ({ack, state} !== 3'b000) begin errors++; $display("FAIL abort_off got=%b exp=000", {ack, state}); end
  endtask

  task automatic test_sleep_drain();
    logic [5:0] pat;
    pat  = 6'b111011;
    sreq = 1'b1; idle = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) begin
      idle = pat[i];
      tick();
      checks++;
      if (sack !== (i == 5)) begin errors++; $display("FAIL sleep_pattern i=%0d got=%b exp=%b", i, sack, (i == 5)); end
    end
    idle = 1'b0;
    tick();
    checks++;
    if (sack !== 1'b1) begin errors++; $display("FAIL sleep_hold got=%b exp=1", sack); end
    sreq = 1'b0;
    tick();
    checks++;
    if (sack !== 1'b0) begin errors++; $display("FAIL sleep_drop got=%b exp=0", sack); end
    sreq = 1'b1; idle = 1'b1;
    tick(); tick();
    sreq = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (sack !== 1'b0) begin errors++; $display("FAIL sleep_abort i=%0d got=%b exp=0", i, sack); end
    end
  endtask

  task automatic test_retention();
    int cnt;
    int first;
    iso = 1'b1; sreq = 1'b1; idle = 1'b1;
    repeat (DRAIN_CYC + 1) tick();
    checks++;
    if (sack !== 1'b1) begin errors++; $display("FAIL ret_sleep_ack got=%b exp=1", sack); end
    ret = 1'b1;
    tick();
    checks++;
    if ({save, restore} !== 2'b10) begin errors++; $display("FAIL ret_save got=%b exp=10", {save, restore}); end
    tick();
    checks++;
    if (save !== 1'b0) begin errors++; $display("FAIL ret_save_width got=%b exp=0", save); end
    ret = 1'b0;
    tick(); tick();
    checks++;
    if (restore !== 1'b0) begin errors++; $display("FAIL ret_restore_unpowered got=%b exp=0", restore); end
    req   = 1'b1;
    cnt   = 0;
    first = -1;
    for (int i = 0; i < ON_DLY + 5; i++) begin
      tick();
      if (restore === 1'b1) begin
        cnt++;
        if (first < 0) first = i;
      end
    end
    checks++;
    if (cnt !== 1) begin errors++; $display("FAIL ret_deferred_count got=%0d exp=1", cnt); end
    checks++;
    if (first !== ON_DLY + 1) begin errors++; $display("FAIL ret_deferred_cycle got=%0d exp=%0d", first, ON_DLY + 1); end
    ret = 1'b1;
    tick(); tick();
    ret = 1'b0;
    tick();
    checks++;
    if (restore !== 1'b1) begin errors++; $display("FAIL ret_restore_powered got=%b exp=1", restore); end
    tick();
    checks++;
    if (restore !== 1'b0) begin errors++; $display("FAIL ret_restore_width got=%b exp=0", restore); end
  endtask

  task automatic test_proto();
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL proto_clean got=%b exp=0", err); end
    iso = 1'b0; req = 1'b0;
    tick();
    checks++;
    if (err !== CHK_EN) begin errors++; $display("FAIL proto_set got=%b exp=%b", err, CHK_EN); end
    iso = 1'b1; req = 1'b1;
    repeat (3) tick();
    checks++;
    if (err !== CHK_EN) begin errors++; $display("FAIL proto_sticky got=%b exp=%b", err, CHK_EN); end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL proto_reset got=%b exp=0", err); end
    tick();
    rst = 1'b0; sreq = 1'b0; req = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_ramp();
    iso = 1'b1; req = 1'b1;
    tick(); tick(); tick();
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({sw_en, ack, sack, save, restore, err, state} !== 8'b0) begin
      errors++; $display("FAIL midramp_reset got=%b exp=00000000", {sw_en, ack, sack, save, restore, err, state});
    end
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if ({sw_en, state} !== 3'b101) begin errors++; $display("FAIL midramp_restart got=%b exp=101", {sw_en, state}); end
    repeat (ON_DLY - 1) tick();
    checks++;
    if (ack !== 1'b0) begin errors++; $display("FAIL midramp_ack_early got=%b exp=0", ack); end
    tick();
    checks++;
    if (ack !== 1'b1) begin errors++; $display("FAIL midramp_ack got=%b exp=1", ack); end
    req = 1'b0;
    repeat (OFF_DLY + 2) tick();
  endtask

  // Reference model: power ack follows completed run lengths of the request,
  // sleep ack follows DRAIN_CYC idle samples after the request was first seen.
  task automatic test_random();
    int hi_run, lo_run, s_run, idle_run;
    logic seen_hi, m_ack, m_sw, m_sack, m_ret_q, pend, m_save, m_rest, m_err;
    logic old_ack, old_sw, old_sack, rise, fall;
    logic [1:0] m_state;
    hi_run = 0; lo_run = 0; s_run = 0; idle_run = 0;
    seen_hi = 0; m_ack = 0; m_sw = 0; m_sack = 0; m_ret_q = 0; pend = 0;
    m_save = 0; m_rest = 0; m_err = 0; m_state = 2'b00;
    rst = 1'b1; req = 0; sreq = 0; iso = 1; ret = 0; idle = 0;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(7) == 0) req = ~req;
      if ($urandom_range(5) == 0) sreq = ~sreq;
      if ($urandom_range(9) == 0) ret = ~ret;
      iso  = ($urandom_range(15) != 0);
      idle = ($urandom_range(3) != 0);
      @(posedge clk);
      old_ack = m_ack; old_sw = m_sw; old_sack = m_sack;
      rise = ret & ~m_ret_q;
      fall = ~ret & m_ret_q;
      if (req) begin hi_run++; lo_run = 0; seen_hi = 1; end
      else begin lo_run++; hi_run = 0; end
      if (hi_run >= ON_DLY + 1) m_ack = 1;
      if (lo_run >= OFF_DLY + 1) m_ack = 0;
      m_sw = req;
      if (req) m_state = (hi_run >= ON_DLY + 1) ? 2'b11 : 2'b01;
      else     m_state = (seen_hi && lo_run < OFF_DLY + 1) ? 2'b10 : 2'b00;
      if (!sreq) begin s_run = 0; idle_run = 0; m_sack = 0; end
      else begin
        s_run++;
        if (s_run == 1) idle_run = 0;
        else if (idle) idle_run++;
        else idle_run = 0;
        if (idle_run >= DRAIN_CYC) m_sack = 1;
      end
      m_save = rise;
      m_rest = 0;
      if (rise) pend = 0;
      else if (fall) begin
        if (old_ack) m_rest = 1;
        else pend = 1;
      end else if (pend && old_ack) begin
        m_rest = 1; pend = 0;
      end
      m_ret_q = ret;
      if (CHK_EN && ((!req && !iso && old_sw) || (rise && !old_sack))) m_err = 1;
      #1;
      checks++; if (sw_en   !== m_sw)    begin errors++; $display("FAIL rnd_sw_en cyc=%0d got=%b exp=%b", i, sw_en, m_sw); end
      checks++; if (ack     !== m_ack)   begin errors++; $display("FAIL rnd_ack cyc=%0d got=%b exp=%b", i, ack, m_ack); end
      checks++; if (state   !== m_state) begin errors++; $display("FAIL rnd_state cyc=%0d got=%b exp=%b", i, state, m_state); end
      checks++; if (sack    !== m_sack)  begin errors++; $display("FAIL rnd_sleep_ack cyc=%0d got=%b exp=%b", i, sack, m_sack); end
      checks++; if (save    !== m_save)  begin errors++; $display("FAIL rnd_save cyc=%0d got=%b exp=%b", i, save, m_save); end
      checks++; if (restore !== m_rest)  begin errors++; $display("FAIL rnd_restore cyc=%0d got=%b exp=%b", i, restore, m_rest); end
      checks++; if (err     !== m_err)   begin errors++; $display("FAIL rnd_proto_err cyc=%0d got=%b exp=%b", i, err, m_err); end
    end
  endtask

  initial begin
    test_reset();
    test_power_up_down();
    test_abort_up();
    test_sleep_drain();
    test_retention();
    test_proto();
    test_reset_mid_ramp();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pd_pwr_responder.md
# pd_pwr_responder

Domain-side responder for the power-controller FSM protocol, sitting at the power-domain boundary in the AON clock domain. It models the power-switch chain: it acknowledges `pwr_on_req` after a programmable ramp and de-acknowledges it after a discharge delay. It returns `hw_sleep_ack` once the domain has drained to idle, and converts retention edges into save/restore strobes. One instance serves each switchable PD (PD1, PD2).

## Interface
Parameters:
- `ON_DLY`, default 8: cycles from the power request being sampled high to `o_pwr_on_ack` rising; legal values are ≥1.
- `OFF_DLY`, default 4: discharge cycles from the request being sampled low to `o_pwr_on_ack` falling; legal values are ≥1.
- `DRAIN_CYC`, default 3: number of consecutive `i_pd_idle` cycles required before a sleep ack; legal values are ≥1.
- `CNT_W`, default 8: width of the shared counter; it must hold max(ON_DLY, OFF_DLY, DRAIN_CYC).

Ports:
- `i_aon_clk` in 1: always-on clock.
- `i_soc_pwr_on_rst` in 1: reset, asynchronous, active-high.
- `i_pwr_on_req` in 1: power-on request from the controller.
- `i_hw_sleep_req` in 1: sleep request from the controller.
- `i_iso` in 1: isolation enable from the controller.
- `i_ret` in 1: retention enable from the controller.
- `i_pd_idle` in 1: high when the domain has no outstanding traffic.
- `o_sw_en` out 1: power-switch chain enable.
- `o_pwr_on_ack` out 1: power-good acknowledge.
- `o_hw_sleep_ack` out 1: sleep acknowledge.
- `o_save_pulse` out 1: one-cycle retention save strobe.
- `o_restore_pulse` out 1: one-cycle retention restore strobe.
- `o_proto_err` out 1: sticky protocol-violation flag.
- `o_pwr_state` out 2: current power FSM state, for test.

## Operation
- Reset values: every output is 0. The power FSM resets to OFF, the sleep FSM to S_RUN, and the counters to 0.
- Power FSM states are OFF=00, RAMP_UP=01, ON=11, RAMP_DOWN=10.
  - OFF: `o_sw_en`=0. If `i_pwr_on_req`=1 → RAMP_UP with the counter cleared.
  - RAMP_UP: `o_sw_en`=1 and the counter increments. When counter==ON_DLY-1 → ON. If `i_pwr_on_req`=0 → RAMP_DOWN with the counter cleared (abort).
  - ON: `o_sw_en`=1. If `i_pwr_on_req`=0 → RAMP_DOWN with the counter cleared.
  - RAMP_DOWN: `o_sw_en`=0 and the counter increments. When counter==OFF_DLY-1 → OFF. If `i_pwr_on_req`=1 → RAMP_UP with the counter cleared.
- `o_pwr_on_ack` is registered:
  - It is set on the RAMP_UP→ON transition and cleared on the RAMP_DOWN→OFF transition; otherwise it holds.
  - An aborted ramp-up therefore never raises ack, and an aborted ramp-down never drops it.
- Sleep FSM states are S_RUN, S_DRAIN, S_ACK (implemented in the `pd_sleep_hs` sub-module).
  - S_RUN: if `i_hw_sleep_req`=1 → S_DRAIN with the idle counter cleared.
  - S_DRAIN: the idle counter increments while `i_pd_idle`=1 and clears on any cycle with `i_pd_idle`=0. When the count reaches DRAIN_CYC-1 with idle still high → S_ACK. If `i_hw_sleep_req`=0 → S_RUN (abort, no ack).
  - S_ACK: `o_hw_sleep_ack`=1. If `i_hw_sleep_req`=0 → S_RUN.
- The sleep FSM is independent of the power FSM. Ack is held through power-off and is dropped only by request deassertion or by reset.
- Retention strobes:
  - A registered copy of `i_ret` is used for edge detection.
  - A rising edge produces `o_save_pulse` for exactly 1 cycle.
  - A falling edge produces `o_restore_pulse` if `o_pwr_on_ack`=1. Otherwise a restore-pending flag is set, and the strobe fires on the first cycle `o_pwr_on_ack`=1 and clears the flag.
  - A new rising edge while a restore is pending clears the pending flag; the save pulse still fires.
- Reset mid-ramp or mid-drain returns all FSMs to their reset state immediately (asynchronous).

## Timing
- Ack latency: if req is sampled high at edge k in OFF, ack is high after edge k+ON_DLY. `o_sw_en` is high after edge k.
- Ack deassert: if req is sampled low at edge k in ON, ack is low after edge k+OFF_DLY. `o_sw_en` is low after edge k.
- Sleep ack: `i_hw_sleep_req` sampled at edge k with `i_pd_idle` continuously high gives ack high after edge k+DRAIN_CYC. Ack falls one cycle after the request is sampled low.
- Save/restore strobes are asserted one cycle after the `i_ret` edge is sampled.

## Configuration
- `PD_PROTO_CHK_EN` defined: `o_proto_err` is set and held until reset when either of these is sampled:
  - `i_pwr_on_req`=0 while `i_iso`=0 (power-down without isolation);
  - `i_ret` rising while `i_hw_sleep_ack`-side state is not S_ACK (save before the domain has drained).
- `PD_PROTO_CHK_EN` undefined: `o_proto_err` is tied to 0 and no checker logic is present.

## Structure
- Package `pd_pwr_pkg` holds the `pwr_state_t` and `sleep_state_t` enums, with encodings as listed above.
- Sub-module `pd_sleep_hs` contains the sleep FSM and idle counter. The top level contains the power FSM, the retention edge logic and the checker.

## Test plan
- ON_DLY=8: req 0→1 at edge 10 → `o_sw_en`=1 after edge 10, ack=1 after edge 18. Req→0 at edge 30 with iso=1 → ack=0 after edge 34.
- Req dropped at cycle 3 of RAMP_UP → RAMP_DOWN, then OFF after 4 cycles; ack never rises.
- Sleep req held with `i_pd_idle` pattern 1,1,0,1,1,1 → ack rises only after the third consecutive idle cycle. Sleep req deasserted in S_DRAIN → no ack.
- `i_ret` rises → `o_save_pulse` is exactly 1 cycle. `i_ret` falls while ack=0 → no strobe; after the power-up ack rises, `o_restore_pulse` fires once.
- With `PD_PROTO_CHK_EN`: req dropped while iso=0 → `o_proto_err`=1 and held. Without the macro → stays 0.
- Reset asserted mid-RAMP_UP → all outputs are 0 and state is OFF; after release, a new ramp takes a full ON_DLY.
